prim_sync_filter: RTL and testbench

Destination-side conditioning stage for asynchronous level inputs entering the clk_i domain. Each input bit passes through a two-flop synchronizer whose first flop is instrumented with prim_cdc_rand_delay. The synchronized value then goes through an optional per-bit debounce filter and an edge detector. It consumes raw pad/foreign-domain levels and produces clean levels plus single-cycle rise/fall pulses for local logic.

---
 rtl/prim_sync_filter.sv | 133 +++++++++++++
 tb/tb_prim_sync_filter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prim_sync_filter.sv
// rtl/prim_sync_filter.sv - two-flop synchronizer with per-bit debounce filter and edge detect
//
// prim_cdc_rand_delay: first-flop instrumentation. When Enable is set, a free-running
// LFSR occasionally makes the first synchronizer flop keep its previous value for one
// cycle. This models a metastability-induced extra cycle of latency. It never skips two
// cycles in a row, so the sync latency stays at 2 or 3 edges.
//   clk_i, rst_ni : clock, async active-low reset
//   prev_data_i   : current first-flop value
//   src_data_i    : asynchronous source value
//   dst_data_o    : value the first flop captures on the next edge
//
// prim_sync_filter: conditions asynchronous level inputs for the clk_i domain.
//   async_i       : raw asynchronous levels
//   filter_en_i   : 1 = debounce active, 0 = filter bypassed
//   thresh_i      : consecutive stable cycles required (0 behaves as 1)
//   sync_o        : synchronized value (second flop)
//   filt_o        : debounced level
//   rise_o/fall_o : one-cycle pulses on filt_o transitions

module prim_cdc_rand_delay #(
    parameter int unsigned DataWidth = 1,
    parameter bit          Enable    = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] prev_data_i,
    input  logic [DataWidth-1:0] src_data_i,
    output logic [DataWidth-1:0] dst_data_o
);
    logic [15:0] lfsr_q, lfsr_d;
    logic        skip_q, skip_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        // A skip is always followed by at least one normal cycle.
        skip_d = Enable & lfsr_q[0] & ~skip_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
            skip_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            skip_q <= skip_d;
        end
    end

    assign dst_data_o = skip_q ? prev_data_i : src_data_i;
endmodule

module prim_sync_filter #(
    parameter int unsigned      Width      = 1,
    parameter int unsigned      CntWidth   = 8,
    parameter logic [Width-1:0] ResetValue = '0,
    parameter bit               EnCdcInstr = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Width-1:0]    async_i,
    input  logic                filter_en_i,
    input  logic [CntWidth-1:0] thresh_i,
    output logic [Width-1:0]    sync_o,
    output logic [Width-1:0]    filt_o,
    output logic [Width-1:0]    rise_o,
    output logic [Width-1:0]    fall_o
);
    logic [Width-1:0]               s1_q, s1_d;
    logic [Width-1:0]               s2_q, s2_d;
    logic [Width-1:0]               filt_q, filt_d;
    logic [Width-1:0]               filt_prev_q, filt_prev_d;
    logic [Width-1:0][CntWidth-1:0] cnt_q, cnt_d;
    logic [Width-1:0][CntWidth:0]   cnt_inc;
    logic [CntWidth:0]              thr_eff;

    prim_cdc_rand_delay #(
        .DataWidth (Width),
        .Enable    (EnCdcInstr)
    ) u_cdc_rand_delay (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .prev_data_i (s1_q),
        .src_data_i  (async_i),
        .dst_data_o  (s1_d)
    );

    always_comb begin
        s2_d        = s1_q;
        filt_prev_d = filt_q;
        filt_d      = filt_q;
        cnt_d       = cnt_q;
        cnt_inc     = '0;
        // A zero threshold would otherwise never be reached; treat it as one cycle.
        thr_eff     = (thresh_i == '0) ? {{CntWidth{1'b0}}, 1'b1} : {1'b0, thresh_i};
        for (int i = 0; i < Width; i++) begin
            // One extra bit so the compare never sees a wrapped count.
            cnt_inc[i] = {1'b0, cnt_q[i]} + {{CntWidth{1'b0}}, 1'b1};
            if (!filter_en_i) begin
                filt_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else if (s2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_inc[i] >= thr_eff) begin
                filt_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_inc[i][CntWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q        <= ResetValue;
            s2_q        <= ResetValue;
            filt_q      <= ResetValue;
            filt_prev_q <= ResetValue;
            cnt_q       <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sync_o = s2_q;
    assign filt_o = filt_q;
    // filt_prev_q resets to the same value as filt_q, so reset release gives no pulse.
    assign rise_o = filt_q & ~filt_prev_q;
    assign fall_o = ~filt_q & filt_prev_q;
endmodule

// File: tb/tb_prim_sync_filter.sv
// tb/tb_prim_sync_filter.sv - self-checking bench for prim_sync_filter
module tb_prim_sync_filter;
    logic       clk = 1'b0;
    logic       rst_ni;
    logic [3:0] async_i;
    logic       filter_en_i;
    logic [7:0] thresh_i;
    logic [3:0] sync_o, filt_o, rise_o, fall_o;
    logic [3:0] c_sync_o, c_filt_o, c_rise_o, c_fall_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prim_sync_filter #(.Width(4), .CntWidth(8), .ResetValue(4'h0), .EnCdcInstr(1'b0)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .async_i(async_i), .filter_en_i(filter_en_i),
        .thresh_i(thresh_i), .sync_o(sync_o), .filt_o(filt_o), .rise_o(rise_o), .fall_o(fall_o)
    );

    prim_sync_filter #(.Width(4), .CntWidth(8), .ResetValue(4'h0), .EnCdcInstr(1'b1)) u_cdc (
        .clk_i(clk), .rst_ni(rst_ni), .async_i(async_i), .filter_en_i(filter_en_i),
        .thresh_i(thresh_i), .sync_o(c_sync_o), .filt_o(c_filt_o), .rise_o(c_rise_o),
        .fall_o(c_fall_o)
    );

    // Free-running pulse counters for the instrumented instance.
    int rise_cnt [4];
    int fall_cnt [4];
    initial for (int i = 0; i < 4; i++) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            rise_cnt[i] += int'(c_rise_o[i]);
            fall_cnt[i] += int'(c_fall_o[i]);
        end
    end

    // Reference model: the synced value is the input two edges late; a filtered bit
    // takes the synced value once the last T synced samples all disagree with it.
    logic [3:0] m_s1, m_s2, m_filt, m_rise, m_fall;
    logic [3:0] hist [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 4'h0; m_s2 = 4'h0; m_filt = 4'h0; m_rise = 4'h0; m_fall = 4'h0;
        hist.delete();
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".sync"}, 32'(sync_o), 32'(m_s2));
        chk({tag, ".filt"}, 32'(filt_o), 32'(m_filt));
        chk({tag, ".rise"}, 32'(rise_o), 32'(m_rise));
        chk({tag, ".fall"}, 32'(fall_o), 32'(m_fall));
    endtask

    task automatic step(input string tag);
        logic [3:0] a, s2p, nf;
        logic       en;
        logic [7:0] th;
        int         t;
        bit         all_diff;
        a  = async_i;
        en = filter_en_i;
        th = thresh_i;
        @(posedge clk);
        #1;
        if (!rst_ni) begin
            model_reset();
        end else begin
            s2p  = m_s2;
            m_s2 = m_s1;
            m_s1 = a;
            hist.push_back(s2p);
            if (hist.size() > 64) void'(hist.pop_front());
            t = (th == 8'd0) ? 1 : int'(th);
            for (int i = 0; i < 4; i++) begin
                if (!en) begin
                    nf[i] = s2p[i];
                end else begin
                    all_diff = (hist.size() >= t);
                    for (int k = 0; k < t && all_diff; k++)
                        if (hist[hist.size() - 1 - k][i] == m_filt[i]) all_diff = 1'b0;
                    nf[i] = all_diff ? ~m_filt[i] : m_filt[i];
                end
            end
            m_rise = nf & ~m_filt;
            m_fall = ~nf & m_filt;
            m_filt = nf;
        end
        check_model(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        int          hold;
        logic [3:0]  prev, nxt;
        int          exp_r [4];
        int          exp_f [4];
        int          base_r [4];
        int          base_f [4];

        // Reset with all inputs high
        rst_ni = 1'b0; async_i = 4'hF; filter_en_i = 1'b0; thresh_i = 8'd4;
        model_reset();
        steps("reset", 3);
        chk("reset.cdc_sync", 32'(c_sync_o), 32'h0);
        chk("reset.cdc_filt", 32'(c_filt_o), 32'h0);
        chk("reset.cdc_pulse", 32'({c_rise_o, c_fall_o}), 32'h0);
        @(negedge clk); rst_ni = 1'b1;
        step("rel1");
        chk("rel1.sync_not_yet", 32'(sync_o), 32'h0);
        step("rel2");
        chk("rel2.sync_f", 32'(sync_o), 32'hF);
        steps("rel", 4);

        // Bypass, bit 0 rising
        @(negedge clk); async_i = 4'h0;
        steps("byp_clr", 6);
        @(negedge clk); async_i = 4'h1;
        step("byp1");
        step("byp2");
        chk("byp.sync_edge2", 32'(sync_o), 32'h1);
        step("byp3");
        chk("byp.filt_edge3", 32'(filt_o), 32'h1);
        chk("byp.rise_edge3", 32'(rise_o), 32'h1);
        step("byp4");
        chk("byp.rise_edge4", 32'(rise_o), 32'h0);

        // Debounce pass, threshold 4
        @(negedge clk); filter_en_i = 1'b1; thresh_i = 8'd4; async_i = 4'h0;
        steps("deb_fall", 10);
        @(negedge clk); async_i = 4'h1;
        steps("deb_rise", 5);
        chk("deb.filt_not_yet", 32'(filt_o), 32'h0);
        step("deb_rise_t");
        chk("deb.filt_after_4", 32'(filt_o), 32'h1);
        chk("deb.single_rise", 32'(rise_o), 32'h1);
        steps("deb_hold", 4);
        @(negedge clk); async_i = 4'h0;
        steps("deb_fall2", 10);

        // Glitch reject then accept
        @(negedge clk); async_i = 4'h1;
        steps("gl_hi", 3);
        @(negedge clk); async_i = 4'h0;
        steps("gl_lo", 8);
        chk("glitch.filt_low", 32'(filt_o), 32'h0);
        @(negedge clk); async_i = 4'h1;
        steps("acc_hi", 4);
        @(negedge clk); async_i = 4'h0;
        steps("acc_lo", 10);

        // Threshold 0 behaves as 1
        @(negedge clk); thresh_i = 8'd0; async_i = 4'hA;
        steps("th0", 5);
        @(negedge clk); async_i = 4'h5;
        steps("th0b", 5);

        // Threshold lowered from 10 to 2 mid-count
        @(negedge clk); thresh_i = 8'd10; async_i = 4'hF;
        steps("thr10", 7);
        @(negedge clk); thresh_i = 8'd2;
        step("thr2_flip");
        chk("thr_drop.flip", 32'(filt_o), 32'hF);
        steps("thr2", 3);

        // Reset asserted mid-count
        @(negedge clk); thresh_i = 8'd10; async_i = 4'h0;
        steps("rc_cnt", 5);
        @(negedge clk); rst_ni = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        steps("rc_hold", 2);
        @(negedge clk); rst_ni = 1'b1;
        steps("rc_rel", 14);

        // Random glitchy stimulus against the model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) async_i = 4'($urandom);
            if ($urandom_range(0, 40) == 0) filter_en_i = ~filter_en_i;
            if ($urandom_range(0, 30) == 0) thresh_i = 8'($urandom_range(0, 6));
            step("rand");
        end

        // Held random changes, both instances; instrumented one checked by window and pulse count
        @(negedge clk); filter_en_i = 1'b1; thresh_i = 8'd3; async_i = 4'h0;
        steps("ins_settle", 12);
        for (int i = 0; i < 4; i++) begin
            exp_r[i] = 0; exp_f[i] = 0;
            base_r[i] = rise_cnt[i]; base_f[i] = fall_cnt[i];
        end
        prev = 4'h0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            nxt = 4'($urandom);
            async_i = nxt;
            for (int i = 0; i < 4; i++) begin
                if (nxt[i] & ~prev[i]) exp_r[i]++;
                if (~nxt[i] & prev[i]) exp_f[i]++;
            end
            prev = nxt;
            hold = int'(thresh_i) + 4;
            steps("ins", hold);
            chk("ins.cdc_sync", 32'(c_sync_o), 32'(nxt));
            chk("ins.cdc_filt", 32'(c_filt_o), 32'(nxt));
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("ins.rise_count", 32'(rise_cnt[i] - base_r[i]), 32'(exp_r[i]));
            chk("ins.fall_count", 32'(fall_cnt[i] - base_f[i]), 32'(exp_f[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
